uart_tx_fifo: RTL and testbench

//  Buffered byte feeder placed directly upstream of async_transmitter.
//  - Accepts bytes from the core/peripheral bus over a valid/ready handshake.
//  - Queues them in a DEPTH-entry FIFO.
//  - Launches each byte into the transmitter with a one-cycle start pulse, gated on the transmitter's busy flag.
//  - Lets software write bursts without polling the transmitter.

---
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding async_transmitter with one-cycle start pulses gated on busy.
// Define UART_TX_CRLF_EN to expand each 8'h0A into the pair 8'h0D, 8'h0A on the wire.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_DONE
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  state_t        state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, avail_q;
  logic          push, pop;
  logic [7:0]    head;
`ifdef UART_TX_CRLF_EN
  logic          crlf_q, crlf_d;
`endif

  assign empty    = (level_q == '0);
  assign wr_ready = (level_q != FULL);
  assign push     = wr_valid & wr_ready;
  assign head     = mem_q[rptr_q];
  assign level    = level_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign idle     = empty & (state_q == S_IDLE) & ~tx_busy;

  always_comb begin
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Launch only on flopped qualifiers; raw busy also blocks so a
  // transmitter still busy through reset never gets a start pulse.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
    crlf_d     = crlf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (avail_q & ~empty & ~tx_busy & ~busy_q) begin
          tx_start_d = 1'b1;
          state_d    = S_ARMED;
`ifdef UART_TX_CRLF_EN
          if ((head == 8'h0A) && !crlf_q) begin
            tx_data_d = 8'h0D;
            crlf_d    = 1'b1;
          end else begin
            tx_data_d = head;
            pop       = 1'b1;
            crlf_d    = 1'b0;
          end
`else
          tx_data_d = head;
          pop       = 1'b1;
`endif
        end
      end
      S_ARMED: begin
        if (busy_q) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!busy_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= tx_busy;
      avail_q    <= ~empty;
    end
  end

`ifdef UART_TX_CRLF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crlf_q <= 1'b0;
    else     crlf_q <= crlf_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter.
// Busy rises one cycle after start and stays high for 10 cycles.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       idle;

  logic       mbusy = 1'b0;
  int         mcnt = 0;
  logic       force_busy = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] log_q [$];
  int         n_checks = 0;
  int         n_fail = 0;

  assign tx_busy = mbusy | force_busy;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level),
    .empty    (empty),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start) begin
      mbusy <= 1'b1;
      mcnt  <= 10;
    end else if (mcnt != 0) begin
      if (mcnt == 1) mbusy <= 1'b0;
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      log_q.push_back(tx_data);
      chk("launch_not_busy", {31'b0, tx_busy}, 0);
      chk("launch_no_b2b", {31'b0, prev_start}, 0);
    end
    prev_start = tx_start;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {31'b0, idle}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    step(1);

    // 1: single byte latency
    wr_data = 8'h55; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    chk("t1_level_n", level, 1);
    chk("t1_start_n", tx_start, 0);
    step(1);
    chk("t1_start_n1", tx_start, 0);
    chk("t1_level_n1", level, 1);
    step(1);
    chk("t1_start_n2", tx_start, 1);
    chk("t1_data_n2", tx_data, 8'h55);
    chk("t1_level_n2", level, 0);
    chk("t1_idle_launch", idle, 0);
    step(12);
    chk("t1_idle_wait", idle, 0);
    step(1);
    chk("t1_idle_done", idle, 1);
    chk("t1_data_hold", tx_data, 8'h55);
    chk("t1_count", log_q.size(), 1);

    // 2: fill while busy, 17th stalls
    log_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'h10 + 8'(i); wr_valid = 1'b1;
      step(1);
    end
    wr_data = 8'h20;
    chk("t2_level_full", level, 16);
    chk("t2_ready_full", wr_ready, 0);
    step(3);
    chk("t2_level_stall", level, 16);
    chk("t2_no_start", tx_start, 0);
    force_busy = 1'b0;
    step(1);
    chk("t2_start_e1", tx_start, 0);
    chk("t2_level_e1", level, 16);
    step(1);
    chk("t2_start_e2", tx_start, 1);
    chk("t2_data_e2", tx_data, 8'h10);
    chk("t2_level_e2", level, 15);
    chk("t2_ready_e2", wr_ready, 1);
    step(1);
    wr_valid = 1'b0;
    chk("t2_level_e3", level, 16);
    chk("t2_ready_e3", wr_ready, 0);
    wait_idle("t2_drain", 400);
    chk("t2_count", log_q.size(), 17);
    chk("t2_first", log_q[0], 8'h10);
    chk("t2_wrap", log_q[15], 8'h1F);
    chk("t2_last", log_q[16], 8'h20);

    // 3: burst order
    log_q.delete();
    for (int i = 1; i <= 4; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      step(1);
    end
    wr_valid = 1'b0;
    chk("t3_level", level, 3);
    wait_idle("t3_drain", 200);
    chk("t3_count", log_q.size(), 4);
    chk("t3_b0", log_q[0], 8'h01);
    chk("t3_b1", log_q[1], 8'h02);
    chk("t3_b2", log_q[2], 8'h03);
    chk("t3_b3", log_q[3], 8'h04);

    // 4: push coincides with launch pop
    log_q.delete();
    wr_data = 8'hA0; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    step(1);
    wr_data = 8'hB0; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    chk("t4_start", tx_start, 1);
    chk("t4_data", tx_data, 8'hA0);
    chk("t4_level", level, 1);
    wait_idle("t4_drain", 100);
    chk("t4_count", log_q.size(), 2);
    chk("t4_b1", log_q[1], 8'hB0);

    // 5: reset mid-transmission
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hC1 + 8'(i); wr_valid = 1'b1;
      step(1);
    end
    wr_valid = 1'b0;
    chk("t5_level", level, 3);
    chk("t5_inflight", tx_data, 8'hC1);
    step(2);
    rst = 1'b1;
    step(1);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_start", tx_start, 0);
    chk("t5_rst_data", tx_data, 8'h00);
    chk("t5_rst_ready", wr_ready, 1);
    chk("t5_rst_idle", idle, 0);
    rst = 1'b0;
    log_q.delete();
    begin
      int n = 0;
      while (tx_busy && n < 30) begin
        step(1);
        n++;
      end
    end
    chk("t5_busy_fell", tx_busy, 0);
    chk("t5_no_launch", log_q.size(), 0);
    wr_data = 8'hD5; wr_valid = 1'b1;
    step(1);
    wr_valid = 1'b0;
    chk("t5_new_level", level, 1);
    step(1);
    chk("t5_new_start_n1", tx_start, 0);
    step(1);
    chk("t5_new_start_n2", tx_start, 1);
    chk("t5_new_data", tx_data, 8'hD5);
    wait_idle("t5_drain", 100);
    chk("t5_count", log_q.size(), 1);

    // 6: line feed handling
    log_q.delete();
    wr_data = 8'h41; wr_valid = 1'b1;
    step(1);
    wr_data = 8'h0A;
    step(1);
    wr_valid = 1'b0;
    wait_idle("t6_drain", 200);
`ifdef UART_TX_CRLF_EN
    chk("t6_count", log_q.size(), 3);
    chk("t6_b0", log_q[0], 8'h41);
    chk("t6_b1", log_q[1], 8'h0D);
    chk("t6_b2", log_q[2], 8'h0A);
`else
    chk("t6_count", log_q.size(), 2);
    chk("t6_b0", log_q[0], 8'h41);
    chk("t6_b1", log_q[1], 8'h0A);
`endif
    chk("t6_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
